// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus bridge: register map, bit positions and
// the byte-transfer state encoding.
package spi_pkg;

  localparam logic [1:0] SPI_REG_DATA   = 2'd0;
  localparam logic [1:0] SPI_REG_STATUS = 2'd1;
  localparam logic [1:0] SPI_REG_CTRL   = 2'd2;
  localparam logic [1:0] SPI_REG_CLKDIV = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_RX_OVF   = 5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IRQ_RX  = 3;
  localparam int CTRL_IRQ_TXE = 4;
  localparam int CTRL_OVF_CLR = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } spi_xfer_state_t;

endpackage

// File: rtl/spi_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_fifo_bridge.sv
// Memory-mapped front end for the SPI shift engine: config registers, TX/RX
// FIFOs and a byte handshake sequencer keeping one byte outstanding.
module spi_fifo_bridge
  import spi_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] CLKDIV_RESET = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        irq,
  output logic [31:0] clkdiv,
  output logic        spi_enable,
  output logic [1:0]  spi_mode,
  output logic [7:0]  spi_data_out,
  output logic        data_out_ready,
  input  logic [7:0]  spi_data_in,
  input  logic        data_in_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            r_enable;
  logic [1:0]      r_mode;
  logic            r_irq_rx_en;
  logic            r_irq_txe_en;
  logic [31:0]     r_clkdiv;
  logic            r_rx_ovf;
  logic [31:0]     r_rdata;
  logic            r_irq;
  spi_xfer_state_t r_state;
  logic [7:0]      r_spi_data_out;
  logic            r_data_out_ready;
  logic            r_din_s1;
  logic            r_din_s2;
  logic            r_din_s3;

  logic [1:0]      w_addr;
  logic            w_tx_push;
  logic            w_tx_pop;
  logic [7:0]      w_tx_head;
  logic            w_tx_full;
  logic            w_tx_empty;
  logic [CW-1:0]   w_tx_count;
  logic            w_rx_push;
  logic            w_rx_pop;
  logic [7:0]      w_rx_head;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic [CW-1:0]   w_rx_count;
  logic            w_byte_done;
  logic            w_rx_drop;
  logic            w_busy;
  logic            w_wr_ctrl;
  logic [31:0]     w_status;
  logic [31:0]     w_rd_word;
  logic            w_unused_ok;

  assign w_addr      = bus_addr[3:2];
  assign w_busy      = (r_state != IDLE);
  assign w_byte_done = r_din_s2 & ~r_din_s3;
  assign w_tx_push   = bus_wen && (w_addr == SPI_REG_DATA) && !w_tx_full;
  assign w_tx_pop    = (r_state == IDLE) && r_enable && !w_tx_empty;
  assign w_rx_pop    = bus_ren && (w_addr == SPI_REG_DATA) && !w_rx_empty;
  // An abort (enable low) takes priority over a completing byte.
  assign w_rx_push   = (r_state == BUSY) && r_enable && w_byte_done;
  assign w_rx_drop   = w_rx_push && w_rx_full && !w_rx_pop;
  assign w_wr_ctrl   = bus_wen && (w_addr == SPI_REG_CTRL);
  assign w_unused_ok = &{1'b0, bus_addr[1:0], w_tx_count, w_rx_count};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_tx_push),
    .wdata (bus_wdata[7:0]),
    .pop   (w_tx_pop),
    .rdata (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_rx_push),
    .wdata (spi_data_in),
    .pop   (w_rx_pop),
    .rdata (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_BUSY]     = w_busy;
    w_status[ST_RX_OVF]   = r_rx_ovf;
  end

  always_comb begin
    w_rd_word = '0;
    case (w_addr)
      SPI_REG_DATA:   w_rd_word = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      SPI_REG_STATUS: w_rd_word = w_status;
      SPI_REG_CTRL:   w_rd_word = {27'd0, r_irq_txe_en, r_irq_rx_en, r_mode, r_enable};
      default:        w_rd_word = r_clkdiv;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enable     <= 1'b0;
      r_mode       <= 2'd0;
      r_irq_rx_en  <= 1'b0;
      r_irq_txe_en <= 1'b0;
      r_clkdiv     <= CLKDIV_RESET;
      r_rx_ovf     <= 1'b0;
      r_rdata      <= 32'd0;
      r_irq        <= 1'b0;
      r_din_s1     <= 1'b0;
      r_din_s2     <= 1'b0;
      r_din_s3     <= 1'b0;
    end else begin
      r_din_s1 <= data_in_ready;
      r_din_s2 <= r_din_s1;
      r_din_s3 <= r_din_s2;
      if (w_wr_ctrl) begin
        r_enable     <= bus_wdata[CTRL_EN];
        r_mode       <= bus_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        r_irq_rx_en  <= bus_wdata[CTRL_IRQ_RX];
        r_irq_txe_en <= bus_wdata[CTRL_IRQ_TXE];
      end
      if (bus_wen && (w_addr == SPI_REG_CLKDIV)) r_clkdiv <= bus_wdata;
      // A fresh overflow wins over a clear landing in the same cycle.
      if (w_rx_drop)                                r_rx_ovf <= 1'b1;
      else if (w_wr_ctrl && bus_wdata[CTRL_OVF_CLR]) r_rx_ovf <= 1'b0;
      if (bus_ren) r_rdata <= w_rd_word;
      r_irq <= (r_irq_rx_en & ~w_rx_empty) | (r_irq_txe_en & w_tx_empty & ~w_busy);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_spi_data_out   <= 8'd0;
      r_data_out_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data_out_ready <= 1'b0;
          if (w_tx_pop) begin
            r_spi_data_out   <= w_tx_head;
            r_data_out_ready <= 1'b1;
            r_state          <= LOAD;
          end
        end
        LOAD: begin
          r_data_out_ready <= 1'b0;
          r_state          <= BUSY;
        end
        BUSY: begin
          r_data_out_ready <= 1'b0;
          if (!r_enable || w_byte_done) r_state <= IDLE;
        end
        default: begin
          r_data_out_ready <= 1'b0;
          r_state          <= IDLE;
        end
      endcase
    end
  end

  assign bus_rdata      = r_rdata;
  assign irq            = r_irq;
  assign clkdiv         = r_clkdiv;
  assign spi_enable     = r_enable;
  assign spi_mode       = r_mode;
  assign spi_data_out   = r_spi_data_out;
  assign data_out_ready = r_data_out_ready;

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Scoreboard bench for spi_fifo_bridge: expected read data and transmitted
// bytes are queued by the stimulus and consumed by a negedge monitor.
module tb_spi_fifo_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_wen = 1'b0;
  logic        bus_ren = 1'b0;
  logic [31:0] bus_rdata;
  logic        irq;
  logic [31:0] clkdiv;
  logic        spi_enable;
  logic [1:0]  spi_mode;
  logic [7:0]  spi_data_out;
  logic        data_out_ready;
  logic [7:0]  spi_data_in = '0;
  logic        data_in_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;
  int served = 0;
  logic rd_flag = 1'b0;
  logic prev_dor = 1'b0;
  logic [31:0] exp_rd [$];
  logic [7:0]  exp_tx [$];

  spi_fifo_bridge #(.FIFO_DEPTH(8), .CLKDIV_RESET(32'd4)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wen        (bus_wen),
    .bus_ren        (bus_ren),
    .bus_rdata      (bus_rdata),
    .irq            (irq),
    .clkdiv         (clkdiv),
    .spi_enable     (spi_enable),
    .spi_mode       (spi_mode),
    .spi_data_out   (spi_data_out),
    .data_out_ready (data_out_ready),
    .spi_data_in    (spi_data_in),
    .data_in_ready  (data_in_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read data appears the cycle after a read strobe; loads on data_out_ready.
  always @(posedge clock) rd_flag <= bus_ren & reset;

  always @(negedge clock) begin
    if (rd_flag) begin
      if (exp_rd.size() == 0) begin
        tests++; fails++;
        $display("FAIL rdata_unexpected: got 0x%0h expected none", bus_rdata);
      end else begin
        check("rdata", bus_rdata, exp_rd.pop_front());
      end
    end
    if (data_out_ready) begin
      load_cnt++;
      check("load_pulse_prev", {31'd0, prev_dor}, 32'd0);
      if (exp_tx.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_unexpected: got 0x%0h expected none", spi_data_out);
      end else begin
        check("tx_byte", {24'd0, spi_data_out}, {24'd0, exp_tx.pop_front()});
      end
    end
    prev_dor = data_out_ready;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    idle(1);
    bus_wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    bus_addr = a; bus_ren = 1'b1;
    idle(1);
    bus_ren = 1'b0;
  endtask

  task automatic wait_load();
    int n = 0;
    while (load_cnt <= served && n < 100) begin
      idle(1);
      n++;
    end
    tests++;
    if (load_cnt <= served) begin
      fails++;
      $display("FAIL load_timeout: got %0d loads expected %0d", load_cnt, served + 1);
    end
    served++;
  endtask

  task automatic engine_byte(input logic [7:0] b);
    wait_load();
    spi_data_in = b;
    data_in_ready = 1'b1;
    idle(4);
    data_in_ready = 1'b0;
    idle(3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset
    idle(3);
    check("rst_dor", {31'd0, data_out_ready}, 32'd0);
    check("rst_sdo", {24'd0, spi_data_out}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    idle(1);
    rd(4'h4, 32'h0A);
    rd(4'hC, 32'd4);
    rd(4'h8, 32'd0);
    check("clkdiv_out_rst", clkdiv, 32'd4);

    // Register read/write and direct outputs
    wr(4'hC, 32'h1234_5678);
    rd(4'hC, 32'h1234_5678);
    check("clkdiv_out", clkdiv, 32'h1234_5678);
    wr(4'h8, 32'h05);
    check("spi_enable", {31'd0, spi_enable}, 32'd1);
    check("spi_mode", {30'd0, spi_mode}, 32'd2);
    rd(4'h8, 32'h05);
    rd(4'h0, 32'd0);

    // Single byte
    wr(4'h8, 32'h01);
    exp_tx.push_back(8'hA5);
    wr(4'h0, 32'hA5);
    engine_byte(8'h3C);
    rd(4'h4, 32'h02);
    rd(4'h0, 32'h3C);
    rd(4'h4, 32'h0A);

    // TX full and drop
    wr(4'h8, 32'h00);
    for (int i = 1; i <= 9; i++) wr(4'h0, i);
    rd(4'h4, 32'h09);
    for (int i = 1; i <= 8; i++) exp_tx.push_back(8'(i));
    wr(4'h8, 32'h01);
    for (int i = 0; i < 8; i++) engine_byte(8'(8'h10 + i));
    rd(4'h4, 32'h06);

    // RX overflow on the ninth received byte
    exp_tx.push_back(8'h0A);
    wr(4'h0, 32'h0A);
    engine_byte(8'hEE);
    rd(4'h4, 32'h26);
    for (int i = 0; i < 8; i++) rd(4'h0, 32'h10 + i);
    rd(4'h4, 32'h2A);
    wr(4'h8, 32'h101);
    rd(4'h4, 32'h0A);
    rd(4'h8, 32'h01);

    // Abort while BUSY
    exp_tx.push_back(8'h55);
    wr(4'h0, 32'h55);
    wr(4'h0, 32'h66);
    wait_load();
    wr(4'h8, 32'h00);
    idle(1);
    rd(4'h4, 32'h08);
    spi_data_in = 8'hDD;
    data_in_ready = 1'b1;
    idle(4);
    data_in_ready = 1'b0;
    idle(3);
    rd(4'h4, 32'h08);
    exp_tx.push_back(8'h66);
    wr(4'h8, 32'h01);
    engine_byte(8'h77);
    rd(4'h0, 32'h77);
    rd(4'h4, 32'h0A);

    // Interrupt and simultaneous RX pop/push
    wr(4'h8, 32'h09);
    idle(2);
    check("irq_idle", {31'd0, irq}, 32'd0);
    exp_tx.push_back(8'h81);
    wr(4'h0, 32'h81);
    engine_byte(8'h91);
    check("irq_rx", {31'd0, irq}, 32'd1);
    exp_tx.push_back(8'h82);
    wr(4'h0, 32'h82);
    wait_load();
    spi_data_in = 8'h92;
    data_in_ready = 1'b1;
    idle(2);
    exp_rd.push_back(32'h91);
    bus_addr = 4'h0; bus_ren = 1'b1;
    idle(1);
    bus_ren = 1'b0;
    idle(1);
    check("irq_simul", {31'd0, irq}, 32'd1);
    idle(2);
    data_in_ready = 1'b0;
    idle(3);
    rd(4'h4, 32'h02);
    rd(4'h0, 32'h92);
    rd(4'h0, 32'h00);
    idle(2);
    check("irq_clear", {31'd0, irq}, 32'd0);
    wr(4'h8, 32'h11);
    idle(2);
    check("irq_txe", {31'd0, irq}, 32'd1);

    // Reset during LOAD
    wr(4'h8, 32'h01);
    wr(4'h0, 32'hC3);
    n = 0;
    while (!data_out_ready && n < 20) begin
      #5;
      n++;
    end
    check("mid_load_seen", {31'd0, data_out_ready}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_dor", {31'd0, data_out_ready}, 32'd0);
    check("mid_rst_sdo", {24'd0, spi_data_out}, 32'd0);
    check("mid_rst_en", {31'd0, spi_enable}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    rd(4'h4, 32'h0A);
    rd(4'hC, 32'd4);
    idle(3);

    check("exp_rd_drained", exp_rd.size(), 32'd0);
    check("exp_tx_drained", exp_tx.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_fifo_bridge.md
Name: spi_fifo_bridge

Overview:
- Memory-mapped front end for the SPI shift engine (spi_controller) on the core's data bus.
- Holds the SPI configuration registers: enable, mode and clock divider.
- Buffers transmit bytes in a TX FIFO and presents them one at a time to the shift engine. Bytes the engine receives are collected into an RX FIFO for software to read.
- Sequences the byte-level handshake so the shift engine only ever sees one outstanding byte.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs (power of two, 2..64)
- CLKDIV_RESET, 32'd4, reset value of the CLKDIV register

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- bus_addr  input  4  byte address; only bits [3:2] are decoded
- bus_wdata  input  32  write data
- bus_wen  input  1  write strobe, one cycle per access
- bus_ren  input  1  read strobe, one cycle per access
- bus_rdata  output  32  read data, registered
- irq  output  1  level interrupt
- clkdiv  output  32  to the shift engine
- spi_enable  output  1  to the shift engine
- spi_mode  output  2  to the shift engine
- spi_data_out  output  8  byte to transmit
- data_out_ready  output  1  one-cycle load strobe to the shift engine
- spi_data_in  input  8  byte received by the shift engine
- data_in_ready  input  1  byte-complete level from the shift engine; treated as asynchronous

Behaviour:
- Register map (word index = bus_addr[3:2]):
  - 0 DATA: write pushes bus_wdata[7:0] into the TX FIFO; read pops the RX FIFO and returns {24'b0, byte}.
  - 1 STATUS (read-only): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] busy, [5] rx_overflow (sticky; cleared by writing 1 to CTRL[8]).
  - 2 CTRL (R/W): [0] enable, [2:1] mode, [3] irq_rx_en, [4] irq_tx_empty_en, [8] write-1-to-clear rx_overflow (reads as 0).
  - 3 CLKDIV (R/W): full 32 bits.
- Bus timing: a read returns its data in bus_rdata on the cycle after bus_ren; bus_rdata is otherwise held. A read of DATA while the RX FIFO is empty returns 0 and does not pop. A write to DATA while the TX FIFO is full is dropped.
- Reset values: all registers 0 except CLKDIV = CLKDIV_RESET. Both FIFOs empty, FSM in IDLE, bus_rdata = 0, data_out_ready = 0, spi_data_out = 0, irq = 0.
- Outputs wired directly from registers: spi_enable = CTRL[0], spi_mode = CTRL[2:1], clkdiv = CLKDIV.
- data_in_ready handling: passed through a 2-flop synchronizer, then a rising-edge detector produces byte_done, a single-cycle pulse.
- Transfer FSM:
  - IDLE: if enable=1 and TX FIFO not empty, pop the FIFO head into spi_data_out and go to LOAD.
  - LOAD: data_out_ready=1 for exactly one cycle, then go to BUSY.
  - BUSY: wait for byte_done. On byte_done, push spi_data_in into the RX FIFO, then go to IDLE.
- Throughput: back-to-back bytes have two cycles of gap (IDLE→LOAD) after each byte_done.
- busy = (state != IDLE).
- RX FIFO full at byte_done: the received byte is discarded and rx_overflow is set.
- Enable cleared while in BUSY: the FSM returns to IDLE immediately. The in-flight byte is lost and no RX push occurs; the TX FIFO keeps its contents.
- Simultaneous FIFO accesses:
  - CPU push and FSM pop of the TX FIFO in the same cycle: both take effect, occupancy unchanged.
  - CPU pop and FSM push of the RX FIFO in the same cycle: both take effect; a full FIFO that is being popped accepts the push.
- FIFO pointers are log2(FIFO_DEPTH) bits plus one wrap bit.
  - Full = indices equal and wrap bits differ; empty = pointers equal.
  - Pointers wrap naturally at FIFO_DEPTH.
- irq = (irq_rx_en & ~rx_empty) | (irq_tx_empty_en & tx_empty & ~busy). Registered, one cycle behind status.
- Reset asserted mid-transfer: everything returns to reset values asynchronously; data_out_ready drops immediately.

Decomposition:
- Shared package spi_pkg holds:
  - the register index constants (SPI_REG_DATA=0, SPI_REG_STATUS=1, SPI_REG_CTRL=2, SPI_REG_CLKDIV=3);
  - the STATUS and CTRL bit-position constants;
  - the FSM state enum typedef spi_xfer_state_t {IDLE, LOAD, BUSY}.
- One sub-module, sync_fifo (parameterised on WIDTH and DEPTH, with push, pop, full, empty and count), instantiated twice: once for TX and once for RX.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release. Read STATUS → 0x0A (tx_empty, rx_empty). Read CLKDIV → 4. Check data_out_ready=0.
- Single byte: write CTRL=0x1, write DATA=0xA5. Check data_out_ready pulses for 1 cycle with spi_data_out=0xA5. Drive spi_data_in=0x3C and raise data_in_ready. Three cycles later read STATUS: rx_empty=0, busy=0. Read DATA → 0x3C.
- TX full and drop: with enable=0, write 9 bytes 0x01..0x09. STATUS tx_full=1. Set enable and complete 8 transfers. Observed spi_data_out sequence is 0x01..0x08; 0x09 was never sent.
- RX overflow: complete 9 transfers without reading RX. STATUS rx_full=1 and rx_overflow=1. Draining returns the first 8 bytes in order. Writing CTRL with bit 8 set clears rx_overflow.
- Abort: clear enable while in BUSY → busy=0 next cycle and no RX push. Re-enable → the next queued byte is loaded.
- Interrupt and simultaneous access: set irq_rx_en. After one received byte, irq=1. Pop DATA in the same cycle as a new byte_done → irq stays 1 and RX count is unchanged.
